// File: rtl/uart_ctrl.sv
// uart_ctrl: TX/RX FIFOs, UartIf pull and receive-interrupt handshake, CPU interrupt
module uart_ctrl #(
    parameter int DW      = 8,
    parameter int TX_AW   = 2,
    parameter int RX_AW   = 2,
    parameter int CLR_CYC = 2
) (
    input  logic          clk_uart,
    input  logic          rst,
    input  logic          tx_wr,
    input  logic [DW-1:0] tx_wdata,
    output logic          tx_full,
    input  logic          rx_rd,
    output logic [DW-1:0] rx_rdata,
    output logic          rx_empty,
    output logic          rx_ovf,
    input  logic          ovf_clr,
    input  logic          irq_en,
    output logic          irq,
    input  logic          uif_r_en,
    output logic [DW-1:0] uif_txd,
    output logic          uif_empty,
    input  logic          uif_rxd_int,
    input  logic [DW-1:0] uif_rdata,
    output logic          rxd_int_fb
);
    typedef enum logic [1:0] {IDLE, PUSH, CLR, WAIT} state_t;
    state_t        state;
    logic [DW-1:0] tx_mem [2**TX_AW];
    logic [DW-1:0] rx_mem [2**RX_AW];
    logic [TX_AW-1:0] tx_wp, tx_rp;
    logic [RX_AW-1:0] rx_wp, rx_rp;
    logic [TX_AW:0] tx_cnt;
    logic [RX_AW:0] rx_cnt;
    logic [DW-1:0] cap;
    logic [3:0]    cyc;
    logic          r_en_q, rxi_q, tx_push, tx_pop, rx_push, rx_full, rx_pop, rx_wr;
    assign tx_full   = tx_cnt[TX_AW];
    assign uif_empty = tx_cnt == '0;
    assign uif_txd   = tx_mem[tx_rp];
    assign tx_push   = tx_wr & ~tx_full;
    assign tx_pop    = uif_r_en & ~r_en_q & ~uif_empty;
    assign rx_full   = rx_cnt[RX_AW];
    assign rx_empty  = rx_cnt == '0;
    assign rx_rdata  = rx_mem[rx_rp];
    assign rx_push   = state == PUSH;
    assign rx_pop    = rx_rd & ~rx_empty;
    // a push into a full FIFO still lands when the head is popped the same cycle
    assign rx_wr     = rx_push & (~rx_full | rx_pop);
    always_ff @(posedge clk_uart or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**TX_AW; i++) tx_mem[i] <= '0;
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            r_en_q <= 1'b0;
        end else begin
            r_en_q <= uif_r_en;
            if (tx_push) tx_mem[tx_wp] <= tx_wdata;
            tx_wp  <= tx_wp + TX_AW'(tx_push);
            tx_rp  <= tx_rp + TX_AW'(tx_pop);
            tx_cnt <= tx_cnt + (TX_AW+1)'(tx_push) - (TX_AW+1)'(tx_pop);
        end
    end
    always_ff @(posedge clk_uart or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**RX_AW; i++) rx_mem[i] <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
            rx_ovf <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (rx_wr) rx_mem[rx_wp] <= cap;
            rx_wp  <= rx_wp + RX_AW'(rx_wr);
            rx_rp  <= rx_rp + RX_AW'(rx_pop);
            rx_cnt <= rx_cnt + (RX_AW+1)'(rx_wr) - (RX_AW+1)'(rx_pop);
            rx_ovf <= (rx_push & rx_full & ~rx_pop) | (rx_ovf & ~ovf_clr);
            irq    <= irq_en & (~rx_empty | rx_ovf);
        end
    end
    always_ff @(posedge clk_uart or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cap        <= '0;
            cyc        <= '0;
            rxi_q      <= 1'b0;
            rxd_int_fb <= 1'b0;
        end else begin
            rxi_q <= uif_rxd_int;
            case (state)
                IDLE: if (uif_rxd_int & ~rxi_q) begin
                    cap        <= uif_rdata;
                    rxd_int_fb <= 1'b1;
                    state      <= PUSH;
                end
                PUSH: begin
                    rxd_int_fb <= 1'b0;
                    cyc        <= '0;
                    state      <= CLR;
                end
                CLR: begin
                    cyc   <= cyc == 4'(CLR_CYC-1) ? '0 : cyc + 4'd1;
                    state <= cyc == 4'(CLR_CYC-1) ? WAIT : CLR;
                end
                WAIT: begin
                    cyc   <= (!uif_rxd_int || cyc == 4'd15) ? '0 : cyc + 4'd1;
                    state <= !uif_rxd_int ? IDLE : cyc == 4'd15 ? CLR : WAIT;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed scenario tests for uart_ctrl
module tb_uart_ctrl;
    logic       clk_uart = 0, rst = 1;
    logic       tx_wr = 0, rx_rd = 0, ovf_clr = 0, irq_en = 0, uif_r_en = 0, uif_rxd_int = 0;
    logic [7:0] tx_wdata = 0, uif_rdata = 0;
    logic       tx_full, rx_empty, rx_ovf, irq, uif_empty, rxd_int_fb;
    logic [7:0] rx_rdata, uif_txd;
    int         checks = 0, errors = 0;

    uart_ctrl dut (
        .clk_uart(clk_uart), .rst(rst), .tx_wr(tx_wr), .tx_wdata(tx_wdata), .tx_full(tx_full),
        .rx_rd(rx_rd), .rx_rdata(rx_rdata), .rx_empty(rx_empty), .rx_ovf(rx_ovf),
        .ovf_clr(ovf_clr), .irq_en(irq_en), .irq(irq), .uif_r_en(uif_r_en), .uif_txd(uif_txd),
        .uif_empty(uif_empty), .uif_rxd_int(uif_rxd_int), .uif_rdata(uif_rdata),
        .rxd_int_fb(rxd_int_fb)
    );

    always #5 clk_uart = ~clk_uart;

    task automatic tick;
        @(posedge clk_uart);
        #1;
    endtask

    task automatic txw(input logic [7:0] b);
        tx_wr = 1; tx_wdata = b; tick; tx_wr = 0;
    endtask

    task automatic pull;
        uif_r_en = 1; tick; uif_r_en = 0; tick;
    endtask

    task automatic pop;
        rx_rd = 1; tick; rx_rd = 0;
    endtask

    // UartIf stand-in: raise rxd_int with a byte, optionally read/clear in the push cycle
    task automatic recv(input logic [7:0] b, input logic rd, input logic clr);
        uif_rdata = b; uif_rxd_int = 1; tick;
        rx_rd = rd; ovf_clr = clr; tick;
        rx_rd = 0; ovf_clr = 0; uif_rxd_int = 0;
        tick; tick; tick;
    endtask

    task automatic test_reset;
        tick; tick;
        checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL reset_tx_full got %h exp 0", tx_full); end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL reset_rx_empty got %h exp 1", rx_empty); end
        checks++; if (uif_empty !== 1'b1) begin errors++; $display("FAIL reset_uif_empty got %h exp 1", uif_empty); end
        checks++; if (uif_txd !== 8'h00) begin errors++; $display("FAIL reset_uif_txd got %h exp 00", uif_txd); end
        checks++; if (rx_rdata !== 8'h00) begin errors++; $display("FAIL reset_rx_rdata got %h exp 00", rx_rdata); end
        checks++; if ({rx_ovf, irq, rxd_int_fb} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {rx_ovf, irq, rxd_int_fb}); end
        rst = 0;
        uif_rdata = 8'h3C; uif_rxd_int = 1; tick;
        checks++; if (rxd_int_fb !== 1'b1) begin errors++; $display("FAIL reset_in_push got %h exp 1", rxd_int_fb); end
        #2 rst = 1;
        #1;
        checks++; if (rxd_int_fb !== 1'b0) begin errors++; $display("FAIL reset_async_fb got %h exp 0", rxd_int_fb); end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL reset_async_rx_empty got %h exp 1", rx_empty); end
        uif_rxd_int = 0; tick; rst = 0; tick; tick;
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL reset_no_push got %h exp 1", rx_empty); end
        checks++; if (rxd_int_fb !== 1'b0) begin errors++; $display("FAIL reset_idle_fb got %h exp 0", rxd_int_fb); end
    endtask

    task automatic test_tx;
        for (int i = 0; i < 4; i++) txw(8'hD9 + 8'(i));
        checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL tx_full got %h exp 1", tx_full); end
        checks++; if (uif_empty !== 1'b0) begin errors++; $display("FAIL tx_not_empty got %h exp 0", uif_empty); end
        txw(8'h00);
        for (int i = 0; i < 4; i++) begin
            checks++; if (uif_txd !== 8'hD9 + 8'(i)) begin errors++; $display("FAIL tx_order got %h exp %h", uif_txd, 8'hD9 + 8'(i)); end
            pull;
        end
        checks++; if (uif_empty !== 1'b1) begin errors++; $display("FAIL tx_drained got %h exp 1", uif_empty); end
        checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL tx_not_full got %h exp 0", tx_full); end
    endtask

    task automatic test_loopback;
        logic [7:0] b;
        irq_en = 1;
        txw(8'h55);
        b = uif_txd;
        pull;
        checks++; if (b !== 8'h55) begin errors++; $display("FAIL lb_txd got %h exp 55", b); end
        uif_rdata = b; uif_rxd_int = 1; tick;
        checks++; if (rxd_int_fb !== 1'b1) begin errors++; $display("FAIL lb_fb_high got %h exp 1", rxd_int_fb); end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL lb_early got %h exp 1", rx_empty); end
        tick;
        checks++; if (rx_rdata !== 8'h55 || rx_empty !== 1'b0) begin errors++; $display("FAIL lb_rdata got %h/%h exp 55/0", rx_rdata, rx_empty); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL lb_irq_early got %h exp 0", irq); end
        checks++; if (rxd_int_fb !== 1'b0) begin errors++; $display("FAIL lb_clr1 got %h exp 0", rxd_int_fb); end
        tick;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL lb_irq got %h exp 1", irq); end
        checks++; if (rxd_int_fb !== 1'b0) begin errors++; $display("FAIL lb_clr2 got %h exp 0", rxd_int_fb); end
        uif_rxd_int = 0; tick; tick;
        pop;
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL lb_read_empty got %h exp 1", rx_empty); end
        tick;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL lb_irq_drop got %h exp 0", irq); end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 4; i++) recv(8'(8'h11 * (i + 1)), 0, 0);
        checks++; if (rx_ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got %h exp 0", rx_ovf); end
        recv(8'h55, 0, 0);
        checks++; if (rx_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %h exp 1", rx_ovf); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rx_rdata !== 8'(8'h11 * (i + 1))) begin errors++; $display("FAIL ovf_order got %h exp %h", rx_rdata, 8'(8'h11 * (i + 1))); end
            pop;
        end
        checks++; if (rx_empty !== 1'b1 || rx_ovf !== 1'b1) begin errors++; $display("FAIL ovf_drained got %h/%h exp 1/1", rx_empty, rx_ovf); end
        ovf_clr = 1; tick; ovf_clr = 0;
        checks++; if (rx_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr got %h exp 0", rx_ovf); end
    endtask

    task automatic test_simultaneous;
        for (int i = 0; i < 4; i++) recv(8'hA1 + 8'(i), 0, 0);
        recv(8'hA5, 1, 0);
        checks++; if (rx_ovf !== 1'b0) begin errors++; $display("FAIL sim_no_ovf got %h exp 0", rx_ovf); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rx_rdata !== 8'hA2 + 8'(i)) begin errors++; $display("FAIL sim_order got %h exp %h", rx_rdata, 8'hA2 + 8'(i)); end
            pop;
        end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL sim_count got %h exp 1", rx_empty); end
        for (int i = 0; i < 4; i++) recv(8'hB1 + 8'(i), 0, 0);
        recv(8'hB5, 0, 1);
        checks++; if (rx_ovf !== 1'b1) begin errors++; $display("FAIL sim_set_wins got %h exp 1", rx_ovf); end
        for (int i = 0; i < 4; i++) pop;
        ovf_clr = 1; tick; ovf_clr = 0;
        for (int i = 0; i < 4; i++) txw(8'hC0 + 8'(i));
        tx_wr = 1; tx_wdata = 8'hEE; uif_r_en = 1; tick;
        tx_wr = 0; uif_r_en = 0; tick;
        checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL sim_tx_full got %h exp 0", tx_full); end
        for (int i = 1; i < 4; i++) begin
            checks++; if (uif_txd !== 8'hC0 + 8'(i)) begin errors++; $display("FAIL sim_tx_order got %h exp %h", uif_txd, 8'hC0 + 8'(i)); end
            pull;
        end
        checks++; if (uif_empty !== 1'b1) begin errors++; $display("FAIL sim_tx_dropped got %h exp 1", uif_empty); end
    endtask

    task automatic test_level_ren;
        txw(8'h71); txw(8'h72); txw(8'h73);
        uif_r_en = 1;
        repeat (10) tick;
        uif_r_en = 0; tick;
        checks++; if (uif_txd !== 8'h72) begin errors++; $display("FAIL lvl_one_pop got %h exp 72", uif_txd); end
        pull;
        checks++; if (uif_txd !== 8'h73) begin errors++; $display("FAIL lvl_next got %h exp 73", uif_txd); end
        pull;
        checks++; if (uif_empty !== 1'b1) begin errors++; $display("FAIL lvl_empty got %h exp 1", uif_empty); end
        pull;
        txw(8'h99);
        checks++; if (uif_txd !== 8'h99 || uif_empty !== 1'b0) begin errors++; $display("FAIL lvl_pop_empty got %h/%h exp 99/0", uif_txd, uif_empty); end
        pull;
    endtask

    initial begin
        test_reset;
        test_tx;
        test_loopback;
        test_overflow;
        test_simultaneous;
        test_level_ren;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
